// File: rtl/mac_psum_buffer_if.sv
// mac_psum_buffer_if: bundle of every non-clock/reset signal of the partial-sum buffer.
//   Issue side : issue_valid/issue_addr/issue_first in, issue_ready out
//   MAC side   : mac_valid_in/mac_c_in out, mac_res_out/mac_store_valid/mac_error_flag in
//   Host side  : rd_en/rd_addr in, rd_data out; busy/err_sticky/sync_err out, err_clr in
// The slave modport is the buffer itself; the master modport is whoever drives it.
interface mac_psum_buffer_if #(
  parameter int AW = 4
);
  logic          issue_valid;
  logic [AW-1:0] issue_addr;
  logic          issue_first;
  logic          issue_ready;
  logic          mac_valid_in;
  logic [63:0]   mac_c_in;
  logic [63:0]   mac_res_out;
  logic          mac_store_valid;
  logic          mac_error_flag;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [63:0]   rd_data;
  logic          busy;
  logic          err_sticky;
  logic          sync_err;
  logic          err_clr;

  modport slave (
    input  issue_valid, issue_addr, issue_first,
    input  mac_res_out, mac_store_valid, mac_error_flag,
    input  rd_en, rd_addr, err_clr,
    output issue_ready, mac_valid_in, mac_c_in, rd_data,
    output busy, err_sticky, sync_err
  );

  modport master (
    output issue_valid, issue_addr, issue_first,
    output mac_res_out, mac_store_valid, mac_error_flag,
    output rd_en, rd_addr, err_clr,
    input  issue_ready, mac_valid_in, mac_c_in, rd_data,
    input  busy, err_sticky, sync_err
  );
endinterface

// File: rtl/mac_psum_buffer.sv
// mac_psum_buffer: partial-sum (C operand) store sitting beside the MAC pipeline.
// Feeds C to the MAC C_LEAD cycles after each issue, writes MAC results back to the
// issuing entry, stalls issues that would read an entry whose accumulation is still
// in flight, and offers a 1-cycle-latency host read port for draining results.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (clears tracker, memory and all flags)
//   bus   : mac_psum_buffer_if.slave (issue, MAC and host signals)
module mac_psum_buffer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int MAC_LAT = 11,
  parameter int C_LEAD  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_psum_buffer_if.slave  bus
);

  localparam int DATA_W  = 64;
  localparam int HAZ_WIN = MAC_LAT - C_LEAD;
  // C is looked up one cycle before it is presented, from the stage holding that issue.
  localparam int C_TAP   = C_LEAD - 1;

  // Tracker: stage k holds the issue accepted k cycles ago; stage MAC_LAT is the tail.
  logic              trk_vld   [1:MAC_LAT];
  logic [AW-1:0]     trk_addr  [1:MAC_LAT];
  logic              trk_first [1:MAC_LAT];

  logic [DATA_W-1:0] mem [DEPTH];

  logic              hazard;
  logic              accept;
  logic              busy_c;
  logic              wb_en;
  logic              wb_mismatch;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] c_p0;
  logic [DATA_W-1:0] rd_p0;
  logic              err_p0;
  logic              sync_p0;

  // Write-first read: a same-cycle writeback to the same entry wins over the array.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [AW-1:0]     ra,
    input logic              we,
    input logic [AW-1:0]     wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] q
  );
    return (we && (wa == ra)) ? wd : q;
  endfunction

  // An entry is unsafe to read while its result lands after this issue's C lookup.
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= HAZ_WIN; k++) begin
      if (trk_vld[k] && (trk_addr[k] == bus.issue_addr)) hazard = 1'b1;
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int k = 1; k <= MAC_LAT; k++) busy_c = busy_c | trk_vld[k];
  end

  assign accept      = bus.issue_valid & ~hazard;
  assign wb_addr     = trk_addr[MAC_LAT];
  assign wb_en       = trk_vld[MAC_LAT] & bus.mac_store_valid;
  assign wb_mismatch = trk_vld[MAC_LAT] ^ bus.mac_store_valid;

  // ---- issue tracker shift line ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 1; k <= MAC_LAT; k++) begin
        trk_vld[k]   <= 1'b0;
        trk_addr[k]  <= '0;
        trk_first[k] <= 1'b0;
      end
    end else begin
      trk_vld[1]   <= accept;
      trk_addr[1]  <= bus.issue_addr;
      trk_first[1] <= bus.issue_first;
      for (int k = 2; k <= MAC_LAT; k++) begin
        trk_vld[k]   <= trk_vld[k-1];
        trk_addr[k]  <= trk_addr[k-1];
        trk_first[k] <= trk_first[k-1];
      end
    end
  end

  // ---- writeback into the partial-sum array ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wb_en) begin
      mem[wb_addr] <= bus.mac_res_out;
    end
  end

  // ---- C operand register and host read register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_p0  <= '0;
      rd_p0 <= '0;
    end else begin
      c_p0 <= '0;
      if (trk_vld[C_TAP] && !trk_first[C_TAP])
        c_p0 <= fwd_read(trk_addr[C_TAP], wb_en, wb_addr, bus.mac_res_out,
                         mem[trk_addr[C_TAP]]);
      if (bus.rd_en)
        rd_p0 <= fwd_read(bus.rd_addr, wb_en, wb_addr, bus.mac_res_out, mem[bus.rd_addr]);
    end
  end

  // ---- sticky flags: clear beats a coincident set ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_p0  <= 1'b0;
      sync_p0 <= 1'b0;
    end else if (bus.err_clr) begin
      err_p0  <= 1'b0;
      sync_p0 <= 1'b0;
    end else begin
      if (wb_en && bus.mac_error_flag) err_p0  <= 1'b1;
      if (wb_mismatch)                 sync_p0 <= 1'b1;
    end
  end

  assign bus.issue_ready  = ~hazard;
  assign bus.mac_valid_in = accept;
  assign bus.mac_c_in     = c_p0;
  assign bus.rd_data      = rd_p0;
  assign bus.busy         = busy_c;
  assign bus.err_sticky   = err_p0;
  assign bus.sync_err     = sync_p0;

endmodule
